// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache shared by several LSUs.
// One request in flight at a time; round-robin arbitration; saturating hit/miss counters.
module dcache_dm #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_LINES     = 8,
  parameter int COUNT_BITS    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready,
  input  logic                                    flush,
  output logic [COUNT_BITS-1:0]                   hit_count,
  output logic [COUNT_BITS-1:0]                   miss_count
);
  localparam int IW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam int CW = $clog2(NUM_CONSUMERS);
  typedef enum logic [2:0] {IDLE, LOOKUP, READ_WAIT, WRITE_WAIT, RELAY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cid_q, cid_d, rr_q, rr_d, k;
  logic op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0][ADDR_BITS-1:0] tag_q, tag_d;
  logic [NUM_LINES-1:0][DATA_BITS-1:0] line_q, line_d;
  logic [NUM_CONSUMERS-1:0] rrdy_q, rrdy_d, wrdy_q, wrdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic mrv_q, mrv_d, mwv_q, mwv_d;
  logic [COUNT_BITS-1:0] hit_q, hit_d, miss_q, miss_d;
  logic [IW-1:0] idx;
  logic hit, found;
  // The whole address is kept as the tag; the index bits always agree, so the compare reduces to the upper bits.
  assign idx = IW'(addr_q & ADDR_BITS'(NUM_LINES - 1));
  assign hit = valid_q[idx] && tag_q[idx] == addr_q;
  assign consumer_read_ready  = rrdy_q;
  assign consumer_read_data   = rdata_q;
  assign consumer_write_ready = wrdy_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = addr_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = addr_q;
  assign mem_write_data       = wdata_q;
  assign hit_count            = hit_q;
  assign miss_count           = miss_q;
  always_comb begin
    state_d = state_q;
    cid_d   = cid_q;
    rr_d    = rr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    rrdy_d  = rrdy_q;
    wrdy_d  = wrdy_q;
    rdata_d = rdata_q;
    mrv_d   = mrv_q;
    mwv_d   = mwv_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    found   = 1'b0;
    k       = '0;
    case (state_q)
      IDLE: begin
        if (flush) valid_d = '0;
        else for (int i = 0; i < NUM_CONSUMERS; i++) begin
          k = CW'((int'(rr_q) + i) % NUM_CONSUMERS);
          if (!found && (consumer_read_valid[k] || consumer_write_valid[k])) begin
            found   = 1'b1;
            cid_d   = k;
            op_d    = !consumer_read_valid[k];
            addr_d  = consumer_read_valid[k] ? consumer_read_address[k] : consumer_write_address[k];
            wdata_d = consumer_write_data[k];
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (op_q) begin
          if (hit) line_d[idx] = wdata_q;
          mwv_d   = 1'b1;
          state_d = WRITE_WAIT;
        end else if (hit) begin
          hit_d          = hit_q + COUNT_BITS'(hit_q != '1);
          rrdy_d[cid_q]  = 1'b1;
          rdata_d[cid_q] = line_q[idx];
          state_d        = RELAY;
        end else begin
          miss_d  = miss_q + COUNT_BITS'(miss_q != '1);
          mrv_d   = 1'b1;
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: if (mem_read_ready) begin
        valid_d[idx]   = 1'b1;
        tag_d[idx]     = addr_q;
        line_d[idx]    = mem_read_data;
        mrv_d          = 1'b0;
        rrdy_d[cid_q]  = 1'b1;
        rdata_d[cid_q] = mem_read_data;
        state_d        = RELAY;
      end
      WRITE_WAIT: if (mem_write_ready) begin
        mwv_d         = 1'b0;
        wrdy_d[cid_q] = 1'b1;
        state_d       = RELAY;
      end
      RELAY: if (!(op_q ? consumer_write_valid[cid_q] : consumer_read_valid[cid_q])) begin
        rrdy_d  = '0;
        wrdy_d  = '0;
        rdata_d = '0;
        rr_d    = cid_q == CW'(NUM_CONSUMERS - 1) ? '0 : cid_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cid_q   <= '0;
      rr_q    <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      line_q  <= '0;
      rrdy_q  <= '0;
      wrdy_q  <= '0;
      rdata_q <= '0;
      mrv_q   <= 1'b0;
      mwv_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cid_q   <= cid_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      rrdy_q  <= rrdy_d;
      wrdy_q  <= wrdy_d;
      rdata_q <= rdata_d;
      mrv_q   <= mrv_d;
      mwv_q   <= mwv_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between NUM_CONSUMERS LSUs and a single global data-memory port.
- Serves one request at a time: a round-robin arbiter selects a consumer, read hits complete without memory traffic, and misses and all writes go to memory.
- Provides hit/miss statistics counters and a whole-cache flush.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, word width; one word per line.
- NUM_CONSUMERS, 4, number of requesters (>=2).
- NUM_LINES, 8, cache lines; power of two, <= 2^ADDR_BITS.
- COUNT_BITS, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  read addresses.
- consumer_read_ready  out  NUM_CONSUMERS  read-complete flag.
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  read data, valid while ready=1.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write addresses.
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data.
- consumer_write_ready  out  NUM_CONSUMERS  write-complete flag.
- mem_read_valid  out  1  memory read request.
- mem_read_address  out  ADDR_BITS  memory read address.
- mem_read_ready  in  1  memory read response strobe.
- mem_read_data  in  DATA_BITS  memory read data, sampled when mem_read_ready=1.
- mem_write_valid  out  1  memory write request.
- mem_write_address  out  ADDR_BITS  memory write address.
- mem_write_data  out  DATA_BITS  memory write data.
- mem_write_ready  in  1  memory write-complete strobe.
- flush  in  1  invalidate all lines.
- hit_count  out  COUNT_BITS  saturating read-hit count.
- miss_count  out  COUNT_BITS  saturating read-miss count.

Behaviour:
Address mapping:
- index = addr[log2(NUM_LINES)-1:0]; tag = the remaining upper bits.
- Each line holds a valid bit, a tag and a data word.

Reset (reset=0, asynchronous, no clock edge needed):
- All outputs go to 0, all valid bits clear, counters clear, round-robin pointer = 0, state = IDLE.
- Reset asserted mid-transaction abandons that transaction; no completion is ever signalled for it.

Consumer handshake (four-phase):
- The consumer holds valid and its address/data stable until the matching ready=1.
- The cache holds ready=1 (and read data stable) until that valid drops, then clears ready.
- Dropping valid before ready is illegal and the cache does not handle it.

Memory handshake:
- The cache holds mem_*_valid and its address/data stable until the corresponding mem_*_ready=1 is sampled.
- It drops valid on that same edge.

States:
- IDLE
  - If flush=1: clear all valid bits and stay in IDLE; flush has priority and no grant is made that cycle. flush outside IDLE is ignored.
  - Otherwise search consumers starting at rr_ptr, wrapping, for the first with read_valid|write_valid. Read wins over write within one consumer.
  - On a hit in the search: latch consumer id, op, address and data, then go to LOOKUP.
- LOOKUP
  - Read hit: increment hit_count; consumer_read_ready[c]=1 with line data; go to RELAY.
  - Read miss: increment miss_count; mem_read_valid=1 with latched address; go to READ_WAIT.
  - Write: if the line is valid with a matching tag, update the line data (write-through); otherwise leave the line untouched (no allocate). Then mem_write_valid=1; go to WRITE_WAIT.
- READ_WAIT
  - On mem_read_ready: fill the line (valid=1, tag, data); drop mem_read_valid; consumer_read_ready[c]=1 with mem_read_data; go to RELAY.
- WRITE_WAIT
  - On mem_write_ready: drop mem_write_valid; consumer_write_ready[c]=1; go to RELAY.
- RELAY
  - When the served consumer's valid for the latched op is 0: clear its ready; rr_ptr = (c+1) mod NUM_CONSUMERS; go to IDLE.

Latency:
- Read hit: ready is visible 2 edges after valid is first sampled high in IDLE.
- Miss/write: ready is visible on the edge that samples mem_*_ready.

Counters:
- hit_count and miss_count saturate at all-ones and do not wrap.
- Writes count toward neither counter.

Never:
- mem_read_valid and mem_write_valid are never both 1.
- At most one ready bit across all consumers is 1 at any time.

Test Plan:
1. Miss then hit: c0 reads 0x13; memory returns 0xAB 3 cycles after request -> one mem_read 0x13, c0 data 0xAB, miss_count=1. c0 reads 0x13 again -> no mem_read_valid, ready 2 edges after valid, data 0xAB, hit_count=1.
2. Conflict (NUM_LINES=8): read 0x03, then 0x0B, then 0x03 -> three memory reads, miss_count=3, hit_count=0.
3. Write-through and no-allocate:
   - After 0x13 is cached, c1 writes 0x55 to 0x13 -> mem write (0x13, 0x55); a later read of 0x13 hits and returns 0x55.
   - c1 writes 0x77 to uncached 0x20 -> mem write only; a later read of 0x20 misses.
4. Round robin: c0, c1 and c2 request reads in the same cycle -> served in order 0, 1, 2. Then c1 and c0 request together -> served 0 then 1 (rr_ptr=3 wraps to 0). No consumer is starved.
5. Flush: cache 0x13, pulse flush for 1 cycle in IDLE -> the next read of 0x13 misses and the memory read is reissued. flush held during READ_WAIT -> no effect.
6. Async reset: assert reset=0 mid-cycle in READ_WAIT -> mem_read_valid, readies and counters go to 0 before the next edge. After release, a read of a previously cached address misses.
